// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO family: width math and configuration checks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   clog2      - ceiling log2, usable in constant expressions
//   is_pow2    - true when a value is a power of two and at least 2
//   thresh_ok  - true when a flag threshold lies within 0..depth
//   def_ptr_t / def_cnt_t - pointer and count types for the default DEPTH of 8
package fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int thresh, input int depth);
    return (thresh >= 0) && (thresh <= depth);
  endfunction

  localparam int DEFAULT_DEPTH = 8;

  // Pointers address DEPTH entries; the count needs one extra bit to hold DEPTH itself.
  typedef logic [clog2(DEFAULT_DEPTH)-1:0] def_ptr_t;
  typedef logic [clog2(DEFAULT_DEPTH):0]   def_cnt_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the synchronous FIFO: one write port, one read port.
// Latency: write lands on the clock edge; read is one cycle (registered) or zero cycles with FIFO_FWFT_EN.
// Backpressure: none; the caller only asserts we/re for accepted transfers.
//
// Ports:
//   clock, reset_n  - clock and synchronous active-low reset (clears only the read register)
//   we, waddr, wdata - write port
//   re, raddr, rdata - read port; re loads the read register in registered mode
// Build option: FIFO_FWFT_EN turns the read port into an asynchronous read of mem[raddr].
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Storage is intentionally not reset.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible combinationally; re and reset_n have no role here.
  assign rdata = mem[raddr];

  logic unused_ok;
  assign unused_ok = &{1'b0, re, reset_n};
`else
  // Registered read: a same-edge write to raddr is not seen, so the old (oldest) word is returned.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end
`endif

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty flags and error pulses.
// Latency: read data one cycle after the read edge (zero with FIFO_FWFT_EN); flags/count update on the same edge.
// Backpressure: writes rejected while full unless a read is accepted on the same edge; rejections pulse overflow/underflow.
//
// Ports:
//   clock, reset_n        - clock, synchronous active-low reset
//   write_en, data_in     - write request and data
//   read_en, data_out     - read request and data (read_en is the pop acknowledge in FWFT mode)
//   full, empty           - count == DEPTH, count == 0
//   almost_full/_empty    - count >= AF_THRESH, count <= AE_THRESH
//   count                 - occupancy 0..DEPTH
//   overflow, underflow   - single-cycle pulses for a rejected write / read
// Build option: FIFO_FWFT_EN selects first-word fall-through reads.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   write_en,
  input  logic                   read_en,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam bit CFG_OK = is_pow2(DEPTH) && thresh_ok(AF_THRESH, DEPTH) && thresh_ok(AE_THRESH, DEPTH);

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("fifo_sync_param: DEPTH must be a power of two >= 2 and thresholds must lie in 0..DEPTH");
    end
  endgenerate

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_THRESH);
  localparam cnt_t AE_C    = cnt_t'(AE_THRESH);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t count_nxt;
  logic wa;
  logic ra;

  // A read frees a slot on the same edge, so a full FIFO can still take a write alongside it.
  assign ra = read_en && !empty;
  assign wa = write_en && (!full || ra);

  always_comb begin
    count_nxt = count;
    case ({wa, ra})
      2'b10:   count_nxt = count + cnt_t'(1);
      2'b01:   count_nxt = count - cnt_t'(1);
      default: count_nxt = count;
    endcase
  end

  // Flags are computed from count_nxt so they move together with count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wa) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (ra) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      overflow     <= write_en && full && !ra;
      underflow    <= read_en && empty;
    end
  end

  // Writes are suppressed during reset so a discarded transfer leaves memory untouched.
  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (wa && reset_n),
    .waddr   (wr_ptr),
    .wdata   (data_in),
    .re      (ra),
    .raddr   (rd_ptr),
    .rdata   (data_out)
  );

endmodule
